// File: rtl/i2c_tgt_pkg.sv
// I2C target controller shared types.
// State encoding and byte framing constants.
package i2c_tgt_pkg;

  localparam int BYTE_W = 8;
  localparam int RW_BIT = 0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RD_FETCH,
    RDATA,
    RD_ACKCHK
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers and bus event detection.
// Emits one-cycle pulses for SCL edges, START and STOP.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl;

  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  // Idle bus is high, so the chain resets to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl;
      sda_q    <= sda;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target protocol controller with register pointer.
// Drives register bank strobes; stretches SCL on reads.
module i2c_target_ctrl
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rvalid,
  output logic       busy
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [BYTE_W-1:0] sh, sh_n;
  logic              rw, rw_n;
  logic [7:0]        addr_n, wdata_n;
  logic              we_n, re_n, scl_n, sda_n, busy_n;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      rw        <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      rw        <= rw_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      reg_re    <= re_n;
      scl_o     <= scl_n;
      sda_o     <= sda_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output decode; bus events override everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    rw_n    = rw;
    addr_n  = reg_addr;
    wdata_n = reg_wdata;
    we_n    = 1'b0;
    re_n    = 1'b0;
    scl_n   = scl_o;
    sda_n   = sda_o;
    busy_n  = busy;
    if (stop_det) begin
      state_n = IDLE;
      cnt_n   = '0;
      scl_n   = 1'b1;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      scl_n   = 1'b1;
      sda_n   = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            sh_n  = {sh[BYTE_W-2:0], sda};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            if (sh[BYTE_W-1:1] == DEV_ADDR) begin
              state_n = ADDR_ACK;
              sda_n   = 1'b0;
              busy_n  = 1'b1;
              rw_n    = sh[RW_BIT];
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_n = 1'b1;
            cnt_n = '0;
            if (rw) begin
              state_n = RD_FETCH;
              scl_n   = 1'b0;
              re_n    = 1'b1;
            end else begin
              state_n = PTR;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            sh_n  = {sh[BYTE_W-2:0], sda};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            addr_n  = sh;
            state_n = PTR_ACK;
            sda_n   = 1'b0;
            cnt_n   = '0;
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_n   = 1'b1;
            state_n = WDATA;
          end
        end
        WDATA: begin
          if (cnt == 4'd8) begin
            wdata_n = sh;
            we_n    = 1'b1;
            state_n = WDATA_ACK;
          end else if (scl_rise) begin
            sh_n  = {sh[BYTE_W-2:0], sda};
            cnt_n = cnt + 4'd1;
          end
        end
        // cnt==8 marks the 8th falling edge still pending.
        WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_n = 1'b0;
              cnt_n = '0;
            end else begin
              sda_n   = 1'b1;
              addr_n  = reg_addr + 8'd1;
              state_n = WDATA;
            end
          end
        end
        RD_FETCH: begin
          if (reg_rvalid) begin
            sh_n    = reg_rdata;
            sda_n   = reg_rdata[BYTE_W-1];
            scl_n   = 1'b1;
            cnt_n   = '0;
            state_n = RDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_n   = 1'b1;
              cnt_n   = '0;
              state_n = RD_ACKCHK;
            end else begin
              sh_n  = {sh[BYTE_W-2:0], 1'b0};
              sda_n = sh[BYTE_W-2];
            end
          end
        end
        // cnt==1 records that the controller ACKed this byte.
        RD_ACKCHK: begin
          if (scl_rise) begin
            if (!sda) begin
              addr_n = reg_addr + 8'd1;
              cnt_n  = 4'd1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && cnt == 4'd1) begin
            state_n = RD_FETCH;
            scl_n   = 1'b0;
            re_n    = 1'b1;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
